// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
package md_pkg;

    // Opcode encodings presented on the Op input.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        StIdle,
        StRun
    } md_state_e;

    // Default latencies in cycles.
    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    // True for the ops that occupy the unit (mult/multu/div/divu).
    function automatic logic is_long_op(logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter used to time multi-cycle md ops; expire flags the final busy cycle.
module md_latency_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;

    // Load on start, otherwise count down to zero and stay there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // A count of 1 means the coming edge ends the op.
    assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide controller with HI/LO registers and stall request.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_MdUse,
    output logic        Busy,
    output logic        Stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e        state_q, state_d;
    logic [2:0]       op_q;
    logic [31:0]      a_q, b_q, hi_q, lo_q;
    logic             start_long, cnt_load, expire, commit;
    logic [CNT_W-1:0] cnt_val;

    logic [63:0]      prod_s, prod_u;
    logic             signed_div;
    logic [31:0]      mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;
    logic             res_wr;
    logic [31:0]      res_hi, res_lo;

    assign start_long = Start & is_long_op(Op);
    assign cnt_val    = is_div_op(Op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_latency_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (Clk),
        .rst      (Rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (expire)
    );

    // Next-state: accept a long op only when idle, finish when the counter expires.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_long) begin
                    cnt_load = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (expire) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result datapath on the latched operands; divides work on magnitudes.
    always_comb begin
        prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u     = {32'b0, a_q} * {32'b0, b_q};
        signed_div = (op_q == MD_DIV);
        mag_a      = (signed_div && a_q[31]) ? -a_q : a_q;
        mag_b      = (signed_div && b_q[31]) ? -b_q : b_q;
        // Substitute 1 for a zero divisor to keep the divider defined; result is discarded.
        div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_mag      = mag_a / div_b;
        r_mag      = mag_a % div_b;
        quot       = (signed_div && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
        rem        = (signed_div && a_q[31]) ? -r_mag : r_mag;

        res_wr = 1'b0;
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        unique case (op_q)
            MD_MULT: begin
                res_wr = 1'b1;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: res_wr = 1'b1;
            MD_DIV, MD_DIVU: begin
                res_wr = (b_q != 32'd0);
                res_hi = rem;
                res_lo = quot;
            end
            default: res_wr = 1'b0;
        endcase
    end

    // State, operand latches and HI/LO architectural registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_load) begin
                op_q <= Op;
                a_q  <= A;
                b_q  <= B;
            end
            if (commit && res_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state_q == StIdle && Start) begin
                if (Op == MD_MTHI) hi_q <= A;
                if (Op == MD_MTLO) lo_q <= A;
            end
        end
    end

    assign Busy      = (state_q == StRun);
    assign Stall_req = D_MdUse & (Busy | start_long);
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: vector table plus hand-written corner sequences.
module tb_md_sequencer;

    logic        Clk, Rst, Start, D_MdUse;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Stall_req;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    md_sequencer dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .D_MdUse   (D_MdUse),
        .Busy      (Busy),
        .Stall_req (Stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Load HI/LO via MTHI/MTLO, checking zero latency and Busy staying low.
    task automatic preset(input logic [31:0] hv, input logic [31:0] lv);
        Start = 1'b1; Op = 3'd5; A = hv;
        tick();
        check("mthi_hi", HI, hv);
        check("mthi_busy", {31'b0, Busy}, 32'd0);
        Op = 3'd6; A = lv;
        tick();
        Start = 1'b0; Op = 3'd0;
        check("mtlo_lo", LO, lv);
        check("mtlo_busy", {31'b0, Busy}, 32'd0);
    endtask

    // Issue one long op with D_MdUse held high and track Busy/Stall_req to the commit.
    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        exp_t e;
        n = (v.op == 3'd3 || v.op == 3'd4) ? 10 : 5;
        e.hi = v.hi;
        e.lo = v.lo;
        sb.push_back(e);
        Start = 1'b1; Op = v.op; A = v.a; B = v.b; D_MdUse = 1'b1;
        #1;
        check($sformatf("v%0d_stall_start", idx), {31'b0, Stall_req}, 32'd1);
        check($sformatf("v%0d_busy_start", idx), {31'b0, Busy}, 32'd0);
        tick();
        Start = 1'b0; Op = 3'd0; A = $urandom; B = $urandom;
        for (int j = 0; j < n; j++) begin
            check($sformatf("v%0d_busy_c%0d", idx, j), {31'b0, Busy}, 32'd1);
            check($sformatf("v%0d_stall_c%0d", idx, j), {31'b0, Stall_req}, 32'd1);
            if (j == n - 1) begin
                check($sformatf("v%0d_hi_early", idx), HI, 32'h11);
                check($sformatf("v%0d_lo_early", idx), LO, 32'h22);
            end
            tick();
        end
        check($sformatf("v%0d_busy_end", idx), {31'b0, Busy}, 32'd0);
        check($sformatf("v%0d_stall_end", idx), {31'b0, Stall_req}, 32'd0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d_scoreboard actual=empty required=entry", idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_hi", idx), HI, e.hi);
            check($sformatf("v%0d_lo", idx), LO, e.lo);
        end
        D_MdUse = 1'b0;
    endtask

    initial begin
        exp_t e;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'd3, 32'd55,       32'd0,        32'h11,       32'h22};
        vecs[5]  = '{3'd4, 32'd55,       32'd0,        32'h11,       32'h22};
        vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
        vecs[7]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
        vecs[8]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[9]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[10] = '{3'd4, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
        vecs[11] = '{3'd1, 32'h12345678, 32'd0,        32'd0,        32'd0};
        vecs[12] = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};

        Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0; D_MdUse = 1'b0;
        #12;
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_stall", {31'b0, Stall_req}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        tick();

        // MTLO 0x1234 while idle.
        Start = 1'b1; Op = 3'd6; A = 32'h1234;
        tick();
        Start = 1'b0; Op = 3'd0;
        check("mtlo_1234", LO, 32'h1234);
        check("mtlo_1234_busy", {31'b0, Busy}, 32'd0);

        // Table of long ops.
        for (int i = 0; i < 13; i++) begin
            preset(32'h11, 32'h22);
            run_vec(vecs[i], i);
        end

        // NONE and op 7 have no effect; MTHI never requests a stall.
        preset(32'h11, 32'h22);
        Start = 1'b1; Op = 3'd0; A = 32'hFFFF;
        tick();
        Op = 3'd7;
        tick();
        check("noop_hi", HI, 32'h11);
        check("noop_lo", LO, 32'h22);
        check("noop_busy", {31'b0, Busy}, 32'd0);
        Op = 3'd5; A = 32'h11; D_MdUse = 1'b1;
        #1;
        check("mthi_nostall", {31'b0, Stall_req}, 32'd0);
        tick();
        Start = 1'b0; Op = 3'd0; D_MdUse = 1'b0;

        // Start while running is ignored; original DIVU commits on schedule.
        preset(32'h11, 32'h22);
        e.hi = 32'd2;
        e.lo = 32'd14;
        sb.push_back(e);
        Start = 1'b1; Op = 3'd4; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0; Op = 3'd0;
        for (int j = 0; j < 10; j++) begin
            check($sformatf("run_busy_c%0d", j), {31'b0, Busy}, 32'd1);
            if (j == 9) begin
                check("run_hi_held", HI, 32'h11);
                check("run_lo_held", LO, 32'h22);
            end
            Start = (j == 3 || j == 4);
            Op    = (j == 3) ? 3'd1 : ((j == 4) ? 3'd6 : 3'd0);
            A     = (j == 4) ? 32'hDEAD : 32'd5;
            B     = 32'd5;
            tick();
        end
        Start = 1'b0; Op = 3'd0;
        check("run_busy_end", {31'b0, Busy}, 32'd0);
        e = sb.pop_front();
        check("run_hi", HI, e.hi);
        check("run_lo", LO, e.lo);

        // Asynchronous reset in cycle 3 of a DIV discards it.
        preset(32'h11, 32'h22);
        Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0; Op = 3'd0;
        tick();
        tick();
        check("mid_busy", {31'b0, Busy}, 32'd1);
        check("mid_stall_nouse", {31'b0, Stall_req}, 32'd0);
        Rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, Busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        Rst = 1'b0;
        for (int j = 0; j < 12; j++) tick();
        check("post_rst_busy", {31'b0, Busy}, 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
